// File: rtl/burst_serial_ctrl_pkg.sv
// Shared types for the burst-to-serializer sequencer.
// Holds the FSM state encoding, word select codes and the bit-count helper.
// Imported by the interface-facing top and the bench.
package burst_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_LOAD,
      S_SHIFT,
      S_NEXT,
      S_DONE
   } state_t;

   localparam logic [1:0] WS_FULL  = 2'b11;
   localparam logic [1:0] WS_LOWER = 2'b01;
   localparam logic [1:0] WS_UPPER = 2'b10;

   // Number of serial bits sent for a given word select
   function automatic logic [4:0] bits_for(input logic [1:0] sel);
      return (sel == WS_FULL) ? 5'd16 : 5'd8;
   endfunction

endpackage

// File: rtl/burst_serial_ctrl_if.sv
// Bundles the command, MRAM and serializer signals of the burst sequencer.
// master = the sequencer itself, slave = host/MRAM/serializer side.
// Widths follow the sequencer parameters.
interface burst_serial_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 8
);
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] start_addr;
   logic [LEN_W-1:0]  burst_len;
   logic [1:0]        word_sel;
   logic              mram_rd;
   logic [ADDR_W-1:0] mram_addr;
   logic [DATA_W-1:0] mram_rdata;
   logic              ser_en;
   logic              ser_load;
   logic              ser_send;
   logic [1:0]        ser_word_sel;
   logic [DATA_W-1:0] ser_data;
   logic              busy;
   logic              word_done;
   logic              done;
   logic              err;

   modport master (
      input  start, abort, start_addr, burst_len, word_sel, mram_rdata,
      output mram_rd, mram_addr, ser_en, ser_load, ser_send, ser_word_sel,
             ser_data, busy, word_done, done, err
   );

   modport slave (
      output start, abort, start_addr, burst_len, word_sel, mram_rdata,
      input  mram_rd, mram_addr, ser_en, ser_load, ser_send, ser_word_sel,
             ser_data, busy, word_done, done, err
   );
endinterface

// File: rtl/burst_serial_ctrl.sv
// Sequences a burst of MRAM reads into an LSB-first serializer, one word at a time.
// Latency: 3+RD_LAT+BITS cycles per word plus one DONE cycle; outputs are registered or state-decoded.
// No backpressure: start is only honoured in IDLE, abort drops the burst on the next edge.
module burst_serial_ctrl
   import burst_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 8,
   parameter int RD_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   burst_serial_ctrl_if.master  bus
);

   // One counter times both the read latency and the shift phase
   localparam int CNT_MAX = (RD_LAT > 16) ? RD_LAT : 16;
   localparam int CNT_W   = $clog2(CNT_MAX);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining;
   logic [1:0]        sel_q;
   logic [DATA_W-1:0] data_q;
   logic              err_q;

   logic cnt_zero;
   logic start_legal;
   logic abort_hit;

   assign cnt_zero    = (cnt == '0);
   assign start_legal = bus.start && (bus.word_sel != 2'b00);
   assign abort_hit   = bus.abort && (state != S_IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; abort overrides every other transition while busy
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_legal)
                     state_nxt = (bus.burst_len == '0) ? S_DONE : S_READ;
         S_READ:  state_nxt = S_WAIT;
         S_WAIT:  if (cnt_zero) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_SHIFT;
         S_SHIFT: if (cnt_zero) state_nxt = S_NEXT;
         S_NEXT:  state_nxt = (remaining == LEN_W'(1)) ? S_DONE : S_READ;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort_hit) state_nxt = S_IDLE;
   end

   // Burst context, shared counter, captured word and error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         addr      <= '0;
         remaining <= '0;
         sel_q     <= 2'b00;
         data_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= (state == S_IDLE) && bus.start && (bus.word_sel == 2'b00);
         if (!abort_hit) begin
            case (state)
               S_IDLE: if (start_legal && (bus.burst_len != '0)) begin
                  addr      <= bus.start_addr;
                  remaining <= bus.burst_len;
                  sel_q     <= bus.word_sel;
               end
               S_READ:  cnt <= CNT_W'(RD_LAT - 1);
               S_WAIT: begin
                  if (cnt_zero) data_q <= bus.mram_rdata;
                  else          cnt    <= cnt - CNT_W'(1);
               end
               S_LOAD:  cnt <= CNT_W'(bits_for(sel_q) - 5'd1);
               S_SHIFT: if (!cnt_zero) cnt <= cnt - CNT_W'(1);
               S_NEXT: begin
                  addr      <= addr + ADDR_W'(1);
                  remaining <= remaining - LEN_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.busy         = (state != S_IDLE);
   assign bus.ser_en       = (state != S_IDLE);
   assign bus.mram_rd      = (state == S_READ);
   assign bus.mram_addr    = addr;
   assign bus.ser_load     = (state == S_LOAD);
   assign bus.ser_send     = (state == S_SHIFT);
   assign bus.word_done    = (state == S_NEXT);
   assign bus.done         = (state == S_DONE);
   assign bus.err          = err_q;
   assign bus.ser_word_sel = sel_q;
   assign bus.ser_data     = data_q;

endmodule

// File: tb/tb_burst_serial_ctrl.sv
// Bench for burst_serial_ctrl: directed scenarios plus randomized bursts.
// A timeline model predicts every strobe from the start cycle and burst parameters.
// MRAM is a bench array behind an RD_LAT-deep read pipeline.
module tb_burst_serial_ctrl;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int LEN_W  = 8;
   localparam int RD_LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   burst_serial_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

   burst_serial_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT))
      dut (.clk(clk), .rst(rst), .bus(bus));

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;
   bit cmp_en    = 0;

   logic [15:0] mem [0:65535];
   logic [15:0] pipe [RD_LAT];

   // model state
   bit          m_active = 0;
   int          m_t0     = 0;
   int          m_err_t  = -1;
   logic [15:0] m_addr;
   int          m_len;
   logic [1:0]  m_sel;

   // monitors
   int          done_cnt = 0, done_cyc = 0, wd_cnt = 0, err_cnt = 0;
   logic [15:0] rd_q [$];
   bit          bits_q [$];
   int          bit_idx = 0, bit_base = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic int m_bits();
      return (m_sel == 2'b11) ? 16 : 8;
   endfunction

   function automatic int m_total();
      return m_len * (3 + RD_LAT + m_bits());
   endfunction

   function automatic bit m_busy(input int c);
      int n;
      if (!m_active) return 0;
      n = c - m_t0 + 1;
      return (n >= 1) && (n <= m_total() + 1);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // MRAM read pipeline: data visible RD_LAT cycles after the strobe
   always @(posedge clk) begin
      pipe[0] <= bus.mram_rd ? mem[bus.mram_addr] : 16'hDEAD;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.mram_rdata = pipe[RD_LAT-1];

   // Per-cycle comparison against the timeline model, plus monitors
   always @(negedge clk) begin
      int n, p, k, o;
      logic [7:0]  e_str, g_str;
      logic [15:0] e_addr;
      bit e_rd, e_load, e_send, e_wd, e_done, e_busy;
      if (cmp_en) begin
         e_rd = 0; e_load = 0; e_send = 0; e_wd = 0; e_done = 0; e_busy = 0;
         e_addr = 16'h0;
         if (m_busy(cyc)) begin
            e_busy = 1;
            n = cyc - m_t0 + 1;
            p = 3 + RD_LAT + m_bits();
            if (n == m_total() + 1) e_done = 1;
            else begin
               k = (n - 1) / p;
               o = (n - 1) % p;
               e_addr = m_addr + 16'(k);
               e_rd   = (o == 0);
               e_load = (o == RD_LAT + 1);
               e_send = (o >= RD_LAT + 2) && (o <= RD_LAT + 1 + m_bits());
               e_wd   = (o == p - 1);
            end
         end
         e_str = {e_busy, e_busy, e_rd, e_load, e_send, e_wd, e_done, 1'(cyc == m_err_t)};
         g_str = {bus.busy, bus.ser_en, bus.mram_rd, bus.ser_load, bus.ser_send,
                  bus.word_done, bus.done, bus.err};
         check("strobes", 64'(g_str), 64'(e_str));
         if (e_rd) check("mram_addr", 64'(bus.mram_addr), 64'(e_addr));
         if (e_load || e_send) check("ser_data", 64'(bus.ser_data), 64'(mem[e_addr]));
         if (e_rd || e_load || e_send || e_wd)
            check("ser_word_sel", 64'(bus.ser_word_sel), 64'(m_sel));
         assert (!(bus.ser_load && bus.ser_send))
            else $error("FAIL load_send_overlap: both high at cycle %0d", cyc);

         if (bus.done) begin done_cnt++; done_cyc = cyc; end
         if (bus.word_done) wd_cnt++;
         if (bus.err) err_cnt++;
         if (bus.mram_rd) rd_q.push_back(bus.mram_addr);
         if (bus.ser_load) begin
            bit_idx = 0;
            bit_base = (bus.ser_word_sel == 2'b10) ? 8 : 0;
         end
         if (bus.ser_send) begin
            bits_q.push_back(bus.ser_data[bit_base + bit_idx]);
            bit_idx++;
         end
      end
   end

   // Advance one cycle and update the model from the inputs sampled at that edge
   task automatic tick();
      bit was_busy, s, a, r;
      logic [15:0] sa;
      logic [7:0]  sl;
      logic [1:0]  sw;
      was_busy = m_busy(cyc);
      s = bus.start; a = bus.abort; r = rst;
      sa = bus.start_addr; sl = bus.burst_len; sw = bus.word_sel;
      @(posedge clk);
      #1;
      if (r) begin
         m_active = 0;
         m_err_t  = -1;
      end else if (!was_busy) begin
         if (s && sw == 2'b00) m_err_t = cyc;
         else if (s) begin
            m_active = 1; m_t0 = cyc; m_addr = sa; m_len = int'(sl); m_sel = sw;
         end
      end else if (a) m_active = 0;
   endtask

   task automatic do_start(input logic [15:0] a, input logic [7:0] l, input logic [1:0] s);
      bus.start_addr = a; bus.burst_len = l; bus.word_sel = s; bus.start = 1;
      tick();
      bus.start = 0;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((bus.busy || m_busy(cyc)) && k < 3000) begin tick(); k++; end
      check({name, "_timeout"}, 64'(k < 3000), 64'(1));
   endtask

   task automatic check_bits(input string name, input int b0, input int len, input logic [15:0] exp);
      logic [15:0] got = 16'h0;
      for (int i = 0; i < len; i++)
         if (b0 + i < bits_q.size()) got[i] = bits_q[b0 + i];
      check(name, 64'(got), 64'(exp));
   endtask

   // Pre-fill with non-zero data so a bad address shows up as a data mismatch
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503 + 12345);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, r0, d0, w0, e0, tmp;
      logic [15:0] exp_seq;
      logic [15:0] a;
      logic [7:0]  l;
      logic [1:0]  s;
      int mode;

      bus.start = 0; bus.abort = 0; bus.start_addr = 0; bus.burst_len = 0; bus.word_sel = 0;
      rst = 1;
      tick(); tick();
      rst = 0;
      cmp_en = 1;
      check("reset_outputs",
            {bus.mram_rd, bus.mram_addr, bus.ser_en, bus.ser_load, bus.ser_send,
             bus.ser_word_sel, bus.ser_data, bus.busy, bus.word_done, bus.done, bus.err}, 64'h0);

      // full-word burst
      mem[16'h0010] = 16'hA5C3; mem[16'h0011] = 16'h0F0F;
      r0 = rd_q.size(); b0 = bits_q.size(); d0 = done_cnt; w0 = wd_cnt;
      do_start(16'h0010, 8'd2, 2'b11);
      tmp = m_t0;
      wait_idle("full");
      check("full_rd_count", 64'(rd_q.size() - r0), 64'd2);
      check("full_addr0", 64'(rd_q[r0]), 64'h0010);
      check("full_addr1", 64'(rd_q[r0 + 1]), 64'h0011);
      check("full_send_count", 64'(bits_q.size() - b0), 64'd32);
      exp_seq = 16'b1010010111000011;  // bit i = i-th serial bit: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
      check_bits("full_word0_bits", b0, 16, exp_seq);
      exp_seq = 16'b0000111100001111;
      check_bits("full_word1_bits", b0 + 16, 16, exp_seq);
      check("full_word_done", 64'(wd_cnt - w0), 64'd2);
      check("full_done_count", 64'(done_cnt - d0), 64'd1);
      check("full_done_cycle", 64'(done_cyc - tmp + 1), 64'd43);

      // upper byte
      mem[16'h0020] = 16'hA5C3;
      b0 = bits_q.size(); d0 = done_cnt;
      do_start(16'h0020, 8'd1, 2'b10);
      tmp = m_t0;
      wait_idle("upper");
      check("upper_send_count", 64'(bits_q.size() - b0), 64'd8);
      exp_seq = 16'h00A5;  // 1,0,1,0,0,1,0,1
      check_bits("upper_bits", b0, 8, exp_seq);
      check("upper_done_cycle", 64'(done_cyc - tmp + 1), 64'd14);

      // zero length
      r0 = rd_q.size(); d0 = done_cnt;
      do_start(16'h0030, 8'd0, 2'b11);
      tmp = m_t0;
      wait_idle("len0");
      check("len0_no_read", 64'(rd_q.size() - r0), 64'd0);
      check("len0_done_count", 64'(done_cnt - d0), 64'd1);
      check("len0_done_cycle", 64'(done_cyc - tmp + 1), 64'd1);

      // illegal word select
      e0 = err_cnt;
      do_start(16'h0040, 8'd3, 2'b00);
      check("sel00_err", 64'(bus.err), 64'd1);
      check("sel00_busy", 64'(bus.busy), 64'd0);
      tick(); tick();
      check("sel00_err_count", 64'(err_cnt - e0), 64'd1);

      // address wrap
      r0 = rd_q.size();
      do_start(16'hFFFF, 8'd2, 2'b01);
      wait_idle("wrap");
      check("wrap_addr1", 64'(rd_q[r0 + 1]), 64'h0000);

      // abort on 5th shift cycle of word 1 of 3
      d0 = done_cnt;
      do_start(16'h0050, 8'd3, 2'b11);
      repeat (8) tick();
      bus.abort = 1;
      tick();
      bus.abort = 0;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_send", 64'(bus.ser_send), 64'd0);
      repeat (30) tick();
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);

      // reset during WAIT, then a clean burst
      do_start(16'h0060, 8'd2, 2'b11);
      tick();
      rst = 1;
      tick();
      rst = 0;
      check("midrst_outputs",
            {bus.mram_rd, bus.mram_addr, bus.ser_en, bus.ser_load, bus.ser_send,
             bus.ser_word_sel, bus.ser_data, bus.busy, bus.word_done, bus.done, bus.err}, 64'h0);
      d0 = done_cnt;
      do_start(16'h0070, 8'd1, 2'b11);
      wait_idle("after_rst");
      check("after_rst_done", 64'(done_cnt - d0), 64'd1);

      // start while busy is ignored
      r0 = rd_q.size(); d0 = done_cnt;
      do_start(16'h0080, 8'd2, 2'b01);
      repeat (5) tick();
      bus.start_addr = 16'h1234; bus.burst_len = 8'd5; bus.start = 1;
      tick();
      bus.start = 0;
      wait_idle("busy_start");
      check("busy_start_rd_count", 64'(rd_q.size() - r0), 64'd2);
      check("busy_start_addr1", 64'(rd_q[r0 + 1]), 64'h0081);
      check("busy_start_done", 64'(done_cnt - d0), 64'd1);

      // randomized bursts against the model
      for (int it = 0; it < 20; it++) begin
         a = 16'($urandom);
         l = 8'($urandom_range(0, 3));
         s = 2'($urandom_range(0, 3));
         mode = $urandom_range(0, 3);
         for (int j = 0; j < 4; j++) mem[a + 16'(j)] = 16'($urandom);
         do_start(a, l, s);
         if (mode == 0) begin
            repeat ($urandom_range(0, 10)) tick();
            bus.abort = 1;
            tick();
            bus.abort = 0;
         end else if (mode == 1) begin
            repeat ($urandom_range(1, 6)) tick();
            bus.start_addr = 16'($urandom);
            bus.start = 1;
            tick();
            bus.start = 0;
         end
         wait_idle("rand");
         if (mode == 2) begin
            bus.abort = 1;
            tick();
            bus.abort = 0;
         end
         tick(); tick();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
